linebuf_window_gen: RTL and testbench

- Streaming multi-channel K x K sliding-window generator for the CFA pipeline. Parametrised successor to the fixed n-channel line-buffer bank.
- Adds a valid/ready handshake on input and output, runtime image width, start-of-frame restart and per-window column/row tags.
- Takes NUM_CH pixels per beat from the memory reader and emits a full K x K window per channel to the filter/interpolation stage.

---
 rtl/linebuf_window_gen_if.sv | 30 +++
 rtl/linebuf_window_gen.sv | 196 +++++++++++++++++++
 tb/tb_linebuf_window_gen.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/linebuf_window_gen_if.sv
// Stream bundle for linebuf_window_gen: pixel-beat input, K x K window output, and frame width.
// The master side is the pixel source and the window sink; the slave side is the window generator.
interface linebuf_window_gen_if #(
  parameter int FILTER_SIZE = 5,
  parameter int NUM_CH      = 4,
  parameter int PIX_W       = 12,
  parameter int COL_W       = 11
);
  logic [COL_W-1:0]                                img_width;
  logic                                            s_valid;
  logic                                            s_ready;
  logic                                            s_sof;
  logic [NUM_CH*PIX_W-1:0]                         s_data;
  logic                                            m_valid;
  logic                                            m_ready;
  logic [NUM_CH*FILTER_SIZE*FILTER_SIZE*PIX_W-1:0] m_data;
  logic [COL_W-1:0]                                m_col;
  logic [COL_W-1:0]                                m_row;
  logic                                            m_eol;

  modport master (
    output img_width, s_valid, s_sof, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_col, m_row, m_eol
  );

  modport slave (
    input  img_width, s_valid, s_sof, s_data, m_ready,
    output s_ready, m_valid, m_data, m_col, m_row, m_eol
  );
endinterface

// File: rtl/linebuf_window_gen.sv
// Streaming multi-channel K x K sliding-window generator with rotating line buffers,
// runtime width, start-of-frame restart and a single registered output stage.
module linebuf_window_gen #(
  parameter int FILTER_SIZE = 5,
  parameter int NUM_CH      = 4,
  parameter int PIX_W       = 12,
  parameter int MAX_WIDTH   = 1024,
  parameter int COL_W       = 11
) (
  input logic                clk,
  input logic                rst,
  linebuf_window_gen_if.slave bus
);
  localparam int K      = FILTER_SIZE;
  localparam int L      = K - 1;
  localparam int BEAT_W = NUM_CH * PIX_W;
  localparam int WIN_W  = NUM_CH * K * K * PIX_W;
  localparam int AW     = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  localparam logic [COL_W-1:0] MAX_W_C  = COL_W'(MAX_WIDTH);
  localparam logic [COL_W-1:0] K_C      = COL_W'(K);
  localparam logic [COL_W-1:0] KM1_C    = COL_W'(K - 1);
  localparam logic [COL_W-1:0] ONE_C    = COL_W'(1);
  localparam logic [COL_W-1:0] ALL_ONES = '1;
  localparam logic [L-1:0]     SEL_INIT = L'(1);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   width_q, width_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [COL_W-1:0]   row_q, row_d;
  logic [L-1:0]       sel_q, sel_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               m_valid_q, m_valid_d;
  logic [WIN_W-1:0]   m_data_q, m_data_d;
  logic [COL_W-1:0]   m_col_q, m_col_d;
  logic [COL_W-1:0]   m_row_q, m_row_d;
  logic               m_eol_q, m_eol_d;

  logic               s_ready_w;
  logic               accept;
  logic               beat;
  logic [COL_W-1:0]   width_in;
  logic [COL_W-1:0]   w_cur;
  logic [COL_W-1:0]   x_cur;
  logic [COL_W-1:0]   y_cur;
  logic [L-1:0]       sel_cur;
  logic               eol_cur;
  logic               w_ok;
  logic               load;

  logic [BEAT_W-1:0]  rd_data [L];
  logic [BEAT_W-1:0]  col_pix [K];

  assign s_ready_w = !m_valid_q || bus.m_ready;
  assign accept    = bus.s_valid && s_ready_w;
  assign beat      = accept && (bus.s_sof || (state_q != IDLE));

  // A sof beat is processed as pixel (0,0) of the new frame in the same cycle it is accepted.
  assign width_in = (bus.img_width > MAX_W_C) ? MAX_W_C : bus.img_width;
  assign w_cur    = bus.s_sof ? width_in : width_q;
  assign x_cur    = bus.s_sof ? '0 : col_q;
  assign y_cur    = bus.s_sof ? '0 : row_q;
  assign sel_cur  = bus.s_sof ? SEL_INIT : sel_q;
  assign eol_cur  = (w_cur == '0) || (x_cur == (w_cur - ONE_C));
  assign w_ok     = (w_cur >= K_C);
  assign load     = beat && w_ok && (x_cur >= KM1_C) && (y_cur >= KM1_C);

  // Reads are prefetched at the next-state column so the data is ready when the beat lands.
  for (genvar gi = 0; gi < L; gi++) begin : g_line
    logic [BEAT_W-1:0] mem [MAX_WIDTH];
    logic [BEAT_W-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (beat && sel_cur[gi]) begin
        mem[x_cur[AW-1:0]] <= bus.s_data;
      end
      rd_q <= mem[col_d[AW-1:0]];
    end

    assign rd_data[gi] = rd_q;
  end

  // Slot holding age r sits r positions above the one-hot's oldest slot.
  always_comb begin
    for (int r = 0; r < L; r++) begin
      col_pix[r] = '0;
      for (int i = 0; i < L; i++) begin
        if (sel_cur[(i - r + L) % L]) begin
          col_pix[r] = col_pix[r] | rd_data[i];
        end
      end
    end
    col_pix[L] = bus.s_data;
  end

  always_comb begin
    win_d = win_q;
    if (beat) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int r = 0; r < K; r++) begin
          for (int k = 0; k < K - 1; k++) begin
            win_d[((c*K + r)*K + k)*PIX_W +: PIX_W] = win_q[((c*K + r)*K + k + 1)*PIX_W +: PIX_W];
          end
          win_d[((c*K + r)*K + K - 1)*PIX_W +: PIX_W] = col_pix[r][c*PIX_W +: PIX_W];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    width_d = width_q;
    col_d   = col_q;
    row_d   = row_q;
    sel_d   = sel_q;

    if (accept && bus.s_sof) begin
      state_d = FILL;
      width_d = width_in;
    end

    if (beat) begin
      if (eol_cur) begin
        col_d = '0;
        row_d = (y_cur == ALL_ONES) ? y_cur : (y_cur + ONE_C);
        sel_d = {sel_cur[L-2:0], sel_cur[L-1]};
      end else begin
        col_d = x_cur + ONE_C;
        row_d = y_cur;
        sel_d = sel_cur;
      end
      if ((state_d == FILL) && (y_cur == KM1_C)) begin
        state_d = RUN;
      end
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_col_d   = m_col_q;
    m_row_d   = m_row_q;
    m_eol_d   = m_eol_q;

    if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end
    if (load) begin
      m_valid_d = 1'b1;
      m_data_d  = win_d;
      m_col_d   = x_cur;
      m_row_d   = y_cur;
      m_eol_d   = eol_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      width_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      sel_q     <= SEL_INIT;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_col_q   <= '0;
      m_row_q   <= '0;
      m_eol_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      col_q     <= col_d;
      row_q     <= row_d;
      sel_q     <= sel_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_col_q   <= m_col_d;
      m_row_q   <= m_row_d;
      m_eol_q   <= m_eol_d;
    end
  end

  // Window shift register is pure datapath; stale columns are flushed before any load.
  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  assign bus.s_ready = s_ready_w;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_col   = m_col_q;
  assign bus.m_row   = m_row_q;
  assign bus.m_eol   = m_eol_q;
endmodule

// File: tb/tb_linebuf_window_gen.sv
// Scoreboard bench for linebuf_window_gen: driver pushes expected windows per accepted beat,
// an independent monitor pops and compares every window handed downstream.
module tb_linebuf_window_gen;
  localparam int K    = 3;
  localparam int NCH  = 2;
  localparam int PW   = 8;
  localparam int MAXW = 16;
  localparam int CW   = 5;
  localparam int DW   = NCH * K * K * PW;

  typedef struct {
    logic [DW-1:0] data;
    int            col;
    int            row;
    bit            eol;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  linebuf_window_gen_if #(.FILTER_SIZE(K), .NUM_CH(NCH), .PIX_W(PW), .COL_W(CW)) bus ();

  linebuf_window_gen #(
    .FILTER_SIZE(K), .NUM_CH(NCH), .PIX_W(PW), .MAX_WIDTH(MAXW), .COL_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t sb_q[$];
  int   tests     = 0;
  int   fails     = 0;
  int   cyc       = 0;
  int   n_win     = 0;
  int   hold_cnt  = 0;
  bit   rand_mode = 1'b0;
  bit   mon_en    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix8(input int x, input int y);
    return 8'((y * 16 + x) & 255);
  endfunction

  function automatic logic [DW-1:0] exp_window(input int x, input int y);
    logic [DW-1:0] v;
    logic [7:0]    p;
    v = '0;
    for (int r = 0; r < K; r++) begin
      for (int k = 0; k < K; k++) begin
        p = pix8(x - K + 1 + k, y - K + 1 + r);
        v[((0*K + r)*K + k)*PW +: PW] = p;
        v[((1*K + r)*K + k)*PW +: PW] = ~p;
      end
    end
    return v;
  endfunction

  // Called at each falling edge; downstream readiness for the coming rising edge.
  task automatic set_ready();
    if (hold_cnt > 0) begin
      bus.m_ready = 1'b0;
      hold_cnt--;
    end else if (rand_mode) begin
      bus.m_ready = 1'($urandom_range(0, 1));
    end else begin
      bus.m_ready = 1'b1;
    end
  endtask

  task automatic send_beat(input bit sof, input int w, input int x, input int y, input bit track);
    exp_t e;
    bit   done;
    int   guard;
    logic [7:0] p;
    done  = 1'b0;
    guard = 0;
    if (rand_mode) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.s_valid = 1'b0;
        @(negedge clk);
        set_ready();
      end
    end
    p = pix8(x, y);
    bus.s_valid   = 1'b1;
    bus.s_sof     = sof;
    bus.img_width = CW'(w);
    bus.s_data    = {~p, p};
    while (!done) begin
      #1;
      if (bus.s_ready) begin
        done = 1'b1;
        if (track && w >= K && x >= K - 1 && y >= K - 1) begin
          e.data = exp_window(x, y);
          e.col  = x;
          e.row  = y;
          e.eol  = (x == w - 1);
          e.cyc  = cyc;
          sb_q.push_back(e);
        end
      end
      @(negedge clk);
      set_ready();
      guard++;
      if (guard > 500) begin
        $display("FAIL input_stall: got s_ready stuck low expected acceptance within 500 cycles");
        $fatal(1, "input stalled");
      end
    end
  endtask

  // Sends a frame row by row; optionally stalls output at beat bp_at, stops after stop_at beats.
  task automatic send_frame(input int w, input int rows, input int bp_at, input int stop_at);
    int idx;
    idx = 0;
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < w; x++) begin
        if (idx == stop_at) return;
        if (idx == bp_at) hold_cnt = 5;
        send_beat(idx == 0, w, x, y, 1'b1);
        idx++;
      end
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    while (sb_q.size() != 0 && g < 300) begin
      @(negedge clk);
      set_ready();
      g++;
    end
    repeat (4) begin
      @(negedge clk);
      set_ready();
    end
    check("drain_queue_empty", DW'(sb_q.size()), '0);
  endtask

  // Monitor: evaluates each cycle after readiness has settled for the coming edge.
  initial begin
    exp_t          e;
    bit            tracking;
    int            first;
    bit            prev_hold;
    logic [DW-1:0] prev_data;
    tracking  = 1'b0;
    first     = 0;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!mon_en) begin
        tracking  = 1'b0;
        prev_hold = 1'b0;
        continue;
      end
      if (prev_hold) begin
        check("hold_valid", DW'(bus.m_valid), DW'(1));
        check("hold_data_stable", bus.m_data, prev_data);
      end
      if (bus.m_valid && !tracking) begin
        tracking = 1'b1;
        first    = cyc;
      end
      if (bus.m_valid && !bus.m_ready) begin
        check("s_ready_backpressure", DW'(bus.s_ready), '0);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (sb_q.size() == 0) begin
          check("spurious_m_valid", DW'(bus.m_valid), '0);
        end else begin
          e = sb_q.pop_front();
          $display("[TB] window col=%0d row=%0d eol=%0d data=%h", bus.m_col, bus.m_row, bus.m_eol, bus.m_data);
          check("win_data", bus.m_data, e.data);
          check("win_col", DW'(bus.m_col), DW'(e.col));
          check("win_row", DW'(bus.m_row), DW'(e.row));
          check("win_eol", DW'(bus.m_eol), DW'(e.eol));
          check("win_latency", DW'(first), DW'(e.cyc + 1));
          n_win++;
        end
        tracking = 1'b0;
      end
      prev_hold = bus.m_valid && !bus.m_ready;
      prev_data = bus.m_data;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    bus.s_valid   = 1'b1;
    bus.s_sof     = 1'b0;
    bus.s_data    = 16'h5aa5;
    bus.img_width = CW'(6);
    bus.m_ready   = 1'b1;
    rst           = 1'b1;

    // Reset with s_valid held high
    repeat (2) @(negedge clk);
    #1;
    check("reset_m_valid", DW'(bus.m_valid), '0);
    check("reset_m_data", bus.m_data, '0);
    check("reset_s_ready", DW'(bus.s_ready), DW'(1));
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    set_ready();
    for (int i = 0; i < 8; i++) send_beat(1'b0, 6, i % 6, 3, 1'b0);
    bus.s_valid = 1'b0;
    #1;
    check("idle_no_output", DW'(bus.m_valid), '0);
    drain();

    // Nominal W=6 frame, 5 rows
    w0 = n_win;
    send_frame(6, 5, -1, -1);
    drain();
    check("nominal_count", DW'(n_win - w0), DW'(12));

    // Backpressure mid-row
    w0 = n_win;
    send_frame(6, 5, 15, -1);
    drain();
    check("backpressure_count", DW'(n_win - w0), DW'(12));

    // Mid-frame sof with a window pending in the output register
    w0 = n_win;
    send_frame(6, 5, -1, 21);
    bus.m_ready = 1'b0;
    hold_cnt    = 2;
    send_frame(4, 4, -1, -1);
    drain();
    check("midframe_sof_count", DW'(n_win - w0), DW'(9));

    // Width below K, then a normal frame
    w0 = n_win;
    send_frame(2, 10, -1, -1);
    drain();
    check("small_width_count", DW'(n_win - w0), '0);
    w0 = n_win;
    send_frame(6, 5, -1, -1);
    drain();
    check("after_small_count", DW'(n_win - w0), DW'(12));

    // Random input gaps and output stalls, W=16
    w0 = n_win;
    rand_mode = 1'b1;
    send_frame(16, 6, -1, -1);
    rand_mode = 1'b0;
    drain();
    check("random_count", DW'(n_win - w0), DW'(56));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
